// File: rtl/button_event_sequencer.sv
// Avalon-MM master for a W-bit button PIO: programs irq_mask once, then drains edge_capture
// on irq or poll and queues non-empty {edges, level} events in a first-word fall-through FIFO.

module button_event_sequencer #(
   parameter int           W           = 4,
   parameter logic [W-1:0] INIT_MASK   = 4'hF,
   parameter int           POLL_CYCLES = 50000,
   parameter int           FIFO_DEPTH  = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   output logic [1:0]    m_address,
   output logic          m_chipselect,
   output logic          m_write_n,
   output logic [31:0]   m_writedata,
   input  logic [31:0]   m_readdata,
   input  logic          pio_irq,
   output logic          evt_valid,
   input  logic          evt_ready,
   output logic [W-1:0]  evt_edges,
   output logic [W-1:0]  evt_level,
   output logic          overflow,
   input  logic          overflow_clr,
   output logic          busy
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   localparam logic [1:0]    ADDR_DATA = 2'd0;
   localparam logic [1:0]    ADDR_MASK = 2'd2;
   localparam logic [1:0]    ADDR_EDGE = 2'd3;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
   localparam logic [31:0]   MASK_WORD = {{(32 - W){1'b0}}, INIT_MASK};

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_RD_EDGE,
      S_WT_EDGE,
      S_CLR,
      S_RD_LVL,
      S_WT_LVL,
      S_PUSH
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [PW-1:0]   poll_cnt;
   logic            poll_hit;

   logic            bus_cs;
   logic            bus_write;
   logic [1:0]      bus_addr;
   logic [31:0]     bus_wdata;

   logic [W-1:0]    edges;
   logic [W-1:0]    level;

   logic [2*W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic            push_ok;

   logic            unused_rdata;

   assign unused_rdata = ^m_readdata[31:W];
   assign poll_hit     = (POLL_CYCLES != 0) && (poll_cnt == POLL_LAST);
   assign busy         = (state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_INIT;
      end else begin
         state <= next_state;
      end
   end

   // Bus requests are decoded from the state being entered so that the strobe is
   // registered and lines up with that state; the mask write is the one exception,
   // issued on the way out of INIT since reset holds the strobe low while in INIT.
   always_comb begin
      next_state = state;
      bus_cs     = 1'b0;
      bus_write  = 1'b0;
      bus_addr   = ADDR_DATA;
      bus_wdata  = 32'h0;

      case (state)
         S_INIT:    next_state = S_IDLE;
         S_IDLE:    if (pio_irq || poll_hit) next_state = S_RD_EDGE;
         S_RD_EDGE: next_state = S_WT_EDGE;
         S_WT_EDGE: next_state = (m_readdata[W-1:0] == '0) ? S_IDLE : S_CLR;
         S_CLR:     next_state = S_RD_LVL;
         S_RD_LVL:  next_state = S_WT_LVL;
         S_WT_LVL:  next_state = S_PUSH;
         S_PUSH:    next_state = S_IDLE;
         default:   next_state = S_INIT;
      endcase

      if (state == S_INIT) begin
         bus_cs    = 1'b1;
         bus_write = 1'b1;
         bus_addr  = ADDR_MASK;
         bus_wdata = MASK_WORD;
      end else begin
         case (next_state)
            S_RD_EDGE: begin
               bus_cs   = 1'b1;
               bus_addr = ADDR_EDGE;
            end
            S_CLR: begin
               bus_cs    = 1'b1;
               bus_write = 1'b1;
               bus_addr  = ADDR_EDGE;
               bus_wdata = 32'hFFFF_FFFF;
            end
            S_RD_LVL: begin
               bus_cs   = 1'b1;
               bus_addr = ADDR_DATA;
            end
            default: bus_cs = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_address    <= 2'd0;
         m_writedata  <= 32'h0;
      end else begin
         m_chipselect <= bus_cs;
         m_write_n    <= ~bus_write;
         m_address    <= bus_addr;
         m_writedata  <= bus_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         poll_cnt <= '0;
      end else if ((state == S_IDLE) && (next_state == S_IDLE)) begin
         poll_cnt <= poll_cnt + PW'(1);
      end else begin
         poll_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edges <= '0;
         level <= '0;
      end else begin
         if (state == S_WT_EDGE) edges <= m_readdata[W-1:0];
         if (state == S_WT_LVL)  level <= m_readdata[W-1:0];
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push    = (state == S_PUSH);
   assign pop     = evt_valid && evt_ready;
   assign push_ok = push && ((count < DEPTH) || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {edges, level};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (push && !push_ok) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

   assign evt_valid = (count != '0);

   always_comb begin
      evt_edges = '0;
      evt_level = '0;
      if (evt_valid) {evt_edges, evt_level} = mem[rd_ptr];
   end

endmodule

// File: tb/tb_button_event_sequencer.sv
// Bench for button_event_sequencer: a PIO model drives the main instance, a second
// instance with a short poll interval and a silent PIO checks the poll cadence.

module tb_button_event_sequencer;

   localparam int POLL_TEST = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  m_address;
   logic        m_chipselect, m_write_n;
   logic [31:0] m_writedata, m_readdata;
   logic        pio_irq, evt_valid, overflow, busy;
   logic        evt_ready = 1'b0;
   logic        overflow_clr = 1'b0;
   logic [3:0]  evt_edges, evt_level;

   logic [1:0]  p_address;
   logic        p_chipselect, p_write_n, p_evt_valid, p_overflow, p_busy;
   logic [31:0] p_writedata;
   logic [3:0]  p_evt_edges, p_evt_level;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   button_event_sequencer #(.W(4), .INIT_MASK(4'hF), .POLL_CYCLES(0), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
      .m_writedata(m_writedata), .m_readdata(m_readdata), .pio_irq(pio_irq),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges),
      .evt_level(evt_level), .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
   );

   button_event_sequencer #(.W(4), .INIT_MASK(4'hF), .POLL_CYCLES(POLL_TEST), .FIFO_DEPTH(4)) dut_poll (
      .clk(clk), .reset_n(reset_n),
      .m_address(p_address), .m_chipselect(p_chipselect), .m_write_n(p_write_n),
      .m_writedata(p_writedata), .m_readdata(32'h0), .pio_irq(1'b0),
      .evt_valid(p_evt_valid), .evt_ready(1'b0), .evt_edges(p_evt_edges),
      .evt_level(p_evt_level), .overflow(p_overflow), .overflow_clr(1'b0), .busy(p_busy)
   );

   // Button PIO model: buttons are active-low, edge_capture records falling edges,
   // irq follows the pressed level through the mask, readdata is registered.
   logic [3:0]  btn = 4'hF;
   logic [3:0]  btn_prev = 4'hF;
   logic [3:0]  pio_mask = 4'h0;
   logic [3:0]  pio_cap = 4'h0;
   logic [31:0] pio_rdata = 32'h0;

   assign m_readdata = pio_rdata;
   assign pio_irq    = |(~btn & pio_mask);

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      btn_prev <= btn;
      if (m_chipselect && !m_write_n && m_address == 2'd3) pio_cap <= btn_prev & ~btn;
      else pio_cap <= pio_cap | (btn_prev & ~btn);
      if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[3:0];
      if (m_chipselect && m_write_n) begin
         case (m_address)
            2'd0:    pio_rdata <= {28'h0, btn};
            2'd2:    pio_rdata <= {28'h0, pio_mask};
            2'd3:    pio_rdata <= {28'h0, pio_cap};
            default: pio_rdata <= 32'h0;
         endcase
      end
   end

   typedef struct {
      int          cyc;
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wd;
   } bus_t;

   bus_t bus_q[$];
   int   p_rd_q[$];
   bit   p_valid_seen = 1'b0;
   bit   p_write_seen = 1'b0;

   always @(negedge clk) begin
      if (m_chipselect) bus_q.push_back('{cyc, m_address, !m_write_n, m_writedata});
      if (p_chipselect && p_write_n && p_address == 2'd3) p_rd_q.push_back(cyc);
      if (p_chipselect && !p_write_n) p_write_seen <= 1'b1;
      if (p_evt_valid) p_valid_seen <= 1'b1;
   end

   task automatic press(input logic [3:0] pressed, output int trig);
      @(posedge clk); #1 btn = ~pressed; trig = cyc;
      @(posedge clk); #1 btn = 4'hF;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({m_chipselect, m_write_n, m_address} !== 4'b0100) begin errors++; $display("[TB] FAIL reset_bus: got cs/wn/addr=%b expected 0100", {m_chipselect, m_write_n, m_address}); end
      checks++; if (m_writedata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", m_writedata); end
      checks++; if ({evt_valid, evt_edges, evt_level} !== 9'h0) begin errors++; $display("[TB] FAIL reset_fifo: got %h expected 0", {evt_valid, evt_edges, evt_level}); end
      checks++; if ({overflow, busy} !== 2'b01) begin errors++; $display("[TB] FAIL reset_status: got ovf/busy=%b expected 01", {overflow, busy}); end
      bus_q.delete();
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (bus_q.size() != 1) begin errors++; $display("[TB] FAIL init_write_count: got %0d expected 1", bus_q.size()); end
      if (bus_q.size() >= 1) begin
         checks++; if ({bus_q[0].wr, bus_q[0].addr} !== 3'b110) begin errors++; $display("[TB] FAIL init_write_addr: got wr/addr=%b expected 110", {bus_q[0].wr, bus_q[0].addr}); end
         checks++; if (bus_q[0].wd !== 32'h0000000F) begin errors++; $display("[TB] FAIL init_write_data: got %h expected 0000000f", bus_q[0].wd); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL init_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single_event();
      int trig;
      int seen;
      evt_ready = 1'b0;
      bus_q.delete();
      press(4'b0010, trig);
      seen = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (evt_valid) begin seen = cyc; break; end
      end
      checks++; if (seen != trig + 7) begin errors++; $display("[TB] FAIL evt_latency: got cycle %0d expected %0d", seen, trig + 7); end
      checks++; if ({evt_edges, evt_level} !== 8'h2F) begin errors++; $display("[TB] FAIL single_event: got %h expected 2f", {evt_edges, evt_level}); end
      checks++; if (bus_q.size() != 3) begin errors++; $display("[TB] FAIL service_access_count: got %0d expected 3", bus_q.size()); end
      if (bus_q.size() >= 3) begin
         checks++; if ({bus_q[0].wr, bus_q[0].addr} !== 3'b011 || bus_q[0].cyc != trig + 1) begin errors++; $display("[TB] FAIL rd_edge: got wr/addr=%b at %0d expected 011 at %0d", {bus_q[0].wr, bus_q[0].addr}, bus_q[0].cyc, trig + 1); end
         checks++; if ({bus_q[1].wr, bus_q[1].addr} !== 3'b111 || bus_q[1].wd !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL clr_write: got wr/addr=%b data %h expected 111 ffffffff", {bus_q[1].wr, bus_q[1].addr}, bus_q[1].wd); end
         checks++; if ({bus_q[2].wr, bus_q[2].addr} !== 3'b000) begin errors++; $display("[TB] FAIL rd_level: got wr/addr=%b expected 000", {bus_q[2].wr, bus_q[2].addr}); end
      end
      @(posedge clk); #1 evt_ready = 1'b1;
      @(posedge clk); #1 evt_ready = 1'b0;
      @(negedge clk);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pop: got valid %b expected 0", evt_valid); end
   endtask

   task automatic test_poll();
      int period;
      period = POLL_TEST + 2;
      bus_q.delete();
      p_rd_q.delete();
      p_valid_seen = 1'b0;
      p_write_seen = 1'b0;
      repeat (45) @(negedge clk);
      checks++; if (p_rd_q.size() < 3) begin errors++; $display("[TB] FAIL poll_reads: got %0d expected at least 3", p_rd_q.size()); end
      for (int i = 1; i < p_rd_q.size(); i++) begin
         checks++; if (p_rd_q[i] - p_rd_q[i-1] != period) begin errors++; $display("[TB] FAIL poll_period: got %0d expected %0d", p_rd_q[i] - p_rd_q[i-1], period); end
      end
      checks++; if (p_valid_seen || p_write_seen) begin errors++; $display("[TB] FAIL poll_empty: got valid_seen=%b write_seen=%b expected 0 0", p_valid_seen, p_write_seen); end
      checks++; if (bus_q.size() != 0) begin errors++; $display("[TB] FAIL no_poll_when_zero: got %0d accesses expected 0", bus_q.size()); end
   endtask

   task automatic test_overflow();
      logic [3:0] ev [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
      int trig;
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         press(ev[i], trig);
         repeat (12) @(posedge clk);
      end
      @(negedge clk);
      checks++; if ({overflow, evt_valid} !== 2'b11) begin errors++; $display("[TB] FAIL overflow_set: got ovf/valid=%b expected 11", {overflow, evt_valid}); end
      @(posedge clk); #1 evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if ({evt_valid, evt_edges, evt_level} !== {1'b1, ev[i], 4'hF}) begin errors++; $display("[TB] FAIL drain_%0d: got %h expected %h", i, {evt_valid, evt_edges, evt_level}, {1'b1, ev[i], 4'hF}); end
      end
      @(negedge clk);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 0", evt_valid); end
      @(posedge clk); #1 evt_ready = 1'b0; overflow_clr = 1'b1;
      @(posedge clk); #1 overflow_clr = 1'b0;
      @(negedge clk);
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_clr: got %b expected 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [3:0] ev [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
      int trig;
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin press(ev[i], trig); repeat (10) @(posedge clk); end
      press(ev[4], trig);
      repeat (5) @(posedge clk); #1 evt_ready = 1'b1;
      @(posedge clk); #1 evt_ready = 1'b0;
      @(negedge clk);
      checks++; if ({overflow, evt_valid, evt_edges, evt_level} !== {2'b01, ev[1], 4'hF}) begin errors++; $display("[TB] FAIL full_push_pop: got %h expected %h", {overflow, evt_valid, evt_edges, evt_level}, {2'b01, ev[1], 4'hF}); end
      @(posedge clk); #1 evt_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         checks++; if ({evt_valid, evt_edges, evt_level} !== {1'b1, ev[i], 4'hF}) begin errors++; $display("[TB] FAIL pushpop_drain_%0d: got %h expected %h", i, {evt_valid, evt_edges, evt_level}, {1'b1, ev[i], 4'hF}); end
      end
      @(negedge clk);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_count: got valid %b expected 0 after four pops", evt_valid); end
      @(posedge clk); #1 evt_ready = 1'b0;

      for (int i = 0; i < 4; i++) begin press(ev[i], trig); repeat (10) @(posedge clk); end
      press(4'h9, trig);
      repeat (5) @(posedge clk); #1 overflow_clr = 1'b1;
      @(posedge clk); #1 overflow_clr = 1'b0;
      @(negedge clk);
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL set_beats_clr: got %b expected 1", overflow); end
      @(posedge clk); #1 evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if ({evt_valid, evt_edges, evt_level} !== {1'b1, ev[i], 4'hF}) begin errors++; $display("[TB] FAIL drop_drain_%0d: got %h expected %h", i, {evt_valid, evt_edges, evt_level}, {1'b1, ev[i], 4'hF}); end
      end
      @(negedge clk);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL dropped_absent: got valid %b expected 0", evt_valid); end
      @(posedge clk); #1 evt_ready = 1'b0; overflow_clr = 1'b1;
      @(posedge clk); #1 overflow_clr = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] exp_q[$];
      bit         done;
      int         pops;
      int         trig;
      logic [3:0] b;
      done = 1'b0;
      pops = 0;
      fork
         begin
            for (int e = 0; e < 16; e++) begin
               b = 4'($urandom_range(1, 15));
               exp_q.push_back(b);
               press(b, trig);
               repeat ($urandom_range(10, 18)) @(posedge clk);
            end
            done = 1'b1;
         end
         begin
            for (int k = 0; k < 2000; k++) begin
               @(posedge clk); #1 evt_ready = ($urandom_range(0, 1) == 1);
               @(negedge clk);
               if (evt_valid && evt_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++; $display("[TB] FAIL rand_unexpected: got %h expected no event", {evt_edges, evt_level});
                  end else begin
                     b = exp_q.pop_front();
                     pops++;
                     if ({evt_edges, evt_level} !== {b, 4'hF}) begin errors++; $display("[TB] FAIL rand_event_%0d: got %h expected %h", pops, {evt_edges, evt_level}, {b, 4'hF}); end
                  end
               end
               if (done && exp_q.size() == 0) break;
            end
         end
      join
      @(posedge clk); #1 evt_ready = 1'b0;
      checks++; if (pops != 16) begin errors++; $display("[TB] FAIL rand_pop_count: got %0d expected 16", pops); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rand_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_reset_mid_service();
      int trig;
      evt_ready = 1'b0;
      press(4'h4, trig);
      repeat (12) @(posedge clk);
      press(4'h8, trig);
      repeat (2) @(posedge clk); #2;
      checks++; if ({m_chipselect, m_write_n, m_address, evt_valid} !== 5'b10111) begin errors++; $display("[TB] FAIL in_clr: got cs/wn/addr/valid=%b expected 10111", {m_chipselect, m_write_n, m_address, evt_valid}); end
      reset_n = 1'b0;
      #1;
      checks++; if ({m_chipselect, m_write_n, m_address} !== 4'b0100 || m_writedata !== 32'h0) begin errors++; $display("[TB] FAIL async_bus: got cs/wn/addr=%b data %h expected 0100 0", {m_chipselect, m_write_n, m_address}, m_writedata); end
      checks++; if ({evt_valid, evt_edges, evt_level, overflow, busy} !== 11'b00000000001) begin errors++; $display("[TB] FAIL async_state: got %b expected 00000000001", {evt_valid, evt_edges, evt_level, overflow, busy}); end
      bus_q.delete();
      repeat (2) @(posedge clk); #1 reset_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++; if (bus_q.size() != 1) begin errors++; $display("[TB] FAIL reinit_count: got %0d expected 1", bus_q.size()); end
      if (bus_q.size() >= 1) begin
         checks++; if ({bus_q[0].wr, bus_q[0].addr} !== 3'b110 || bus_q[0].wd !== 32'h0000000F) begin errors++; $display("[TB] FAIL reinit_write: got wr/addr=%b data %h expected 110 0000000f", {bus_q[0].wr, bus_q[0].addr}, bus_q[0].wd); end
      end
      checks++; if ({evt_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL reinit_empty: got valid/busy=%b expected 00", {evt_valid, busy}); end
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_poll();
      test_overflow();
      test_full_push_pop();
      test_random();
      test_reset_mid_service();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
